// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register file write port between the writeback
// stage, which normally wins, and a small FIFO of multiply/divide results.
// A starvation counter lets an aged FIFO head preempt the pipeline for one cycle.
module rf_write_arbiter #(
  parameter int XLEN         = 64,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_valid,
  input  logic                     wb_we,
  input  logic [4:0]               wb_rd,
  input  logic [XLEN-1:0]          wb_data,
  output logic                     wb_stall,
  input  logic                     mdu_valid,
  input  logic [4:0]               mdu_rd,
  input  logic [XLEN-1:0]          mdu_data,
  output logic                     mdu_ready,
  output logic                     rf_we,
  output logic [4:0]               rf_rd,
  output logic [XLEN-1:0]          rf_data,
  output logic                     rf_src,
  output logic [$clog2(DEPTH):0]   pending_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [3:0]    LIMIT = 4'(STARVE_LIMIT);
  localparam logic [CW-1:0] FULL  = CW'(DEPTH);

  logic [4:0]      mem_rd_q   [DEPTH];
  logic [4:0]      mem_rd_d   [DEPTH];
  logic [XLEN-1:0] mem_data_q [DEPTH];
  logic [XLEN-1:0] mem_data_d [DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      starve_q, starve_d;

  logic wb_req;
  logic head_due;
  logic grant_fifo;
  logic grant_wb;
  logic push;
  logic pop;

  // Grant decision and port muxing; all outputs forced quiet while reset is held.
  always_comb begin
    wb_req     = wb_valid & wb_we;
    head_due   = (cnt_q != '0) && (starve_q == LIMIT);
    grant_fifo = reset && (cnt_q != '0) && (head_due || !wb_req);
    grant_wb   = reset && wb_req && !head_due;
    wb_stall   = reset && wb_req && head_due;
    rf_src     = grant_fifo;
    rf_rd      = '0;
    rf_data    = '0;
    if (grant_fifo) begin
      rf_rd   = mem_rd_q[head_q];
      rf_data = mem_data_q[head_q];
    end else if (grant_wb) begin
      rf_rd   = wb_rd;
      rf_data = wb_data;
    end
    rf_we       = (grant_fifo || grant_wb) && (rf_rd != 5'd0);
    mdu_ready   = (cnt_q < FULL);
    pending_cnt = cnt_q;
  end

  // Next FIFO contents, pointers, occupancy and head age; x0 results are dropped on entry.
  always_comb begin
    push       = mdu_valid && mdu_ready && (mdu_rd != 5'd0);
    pop        = grant_fifo;
    mem_rd_d   = mem_rd_q;
    mem_data_d = mem_data_q;
    head_d     = head_q;
    tail_d     = tail_q;
    if (push) begin
      mem_rd_d[tail_q]   = mdu_rd;
      mem_data_d[tail_q] = mdu_data;
      tail_d             = tail_q + PW'(1);
    end
    if (pop) begin
      head_d = head_q + PW'(1);
    end
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    starve_d = starve_q;
    if (pop || (cnt_d == '0)) begin
      starve_d = '0;
    end else if ((cnt_q != '0) && (starve_q != LIMIT)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // State registers; reset discards any buffered results.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_rd_q[i]   <= '0;
        mem_data_q[i] <= '0;
      end
      head_q   <= '0;
      tail_q   <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
    end else begin
      mem_rd_q   <= mem_rd_d;
      mem_data_q <= mem_data_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
    end
  end

endmodule
